// File: rtl/approx_mult_pipe_pkg.sv
// Shared definitions for the approximate multiplier: mode encoding and the
// compensated low sub-product.
package approx_mult_pipe_pkg;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  localparam int unsigned LL_MAX_W = 64;

  // Zero the low trunc bits and set bit trunc-1 as compensation. A half-width
  // product is nonzero exactly when both halves are nonzero, so ll != 0
  // stands in for (al != 0 && bl != 0).
  function automatic logic [LL_MAX_W-1:0] approx_ll(input logic [LL_MAX_W-1:0] ll,
                                                    input int unsigned         trunc);
    logic [LL_MAX_W-1:0] mask;
    logic [LL_MAX_W-1:0] res;
    mask = '1;
    if (trunc >= LL_MAX_W) mask = '0;
    else                   mask = mask << trunc;
    res = ll & mask;
    if (trunc != 0 && trunc <= LL_MAX_W && ll != '0)
      res = res | (LL_MAX_W'(1) << (trunc - 1));
    return res;
  endfunction

endpackage

// File: rtl/approx_mult_pipe_half_mult.sv
// Unsigned H x H combinational multiplier used for the four sub-products.
module half_mult #(
  parameter int unsigned H = 4
) (
  input  logic [H-1:0]   a_i,
  input  logic [H-1:0]   b_i,
  output logic [2*H-1:0] p_o
);

  assign p_o = (2*H)'(a_i) * (2*H)'(b_i);

endmodule

// File: rtl/approx_mult_pipe.sv
// Three-stage valid/ready multiplier built from half-width sub-products, with
// per-operation exact or truncated-and-compensated low sub-product.
module approx_mult_pipe
  import approx_mult_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TRUNC = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_r,
  output logic               out_mode,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int unsigned H  = WIDTH / 2;
  localparam int unsigned RW = 2 * WIDTH;

  logic             adv;
  logic [WIDTH-1:0] ll_c, hl_c, lh_c, hh_c;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_ll_q, s1_hl_q, s1_lh_q, s1_hh_q;
  logic             s1_mode_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             s2_valid_q;
  logic [RW-1:0]    s2_sum_q, s2_sum_d;
  logic             s2_mode_q;
  logic [TAG_W-1:0] s2_tag_q;

  logic             out_valid_q;
  logic [RW-1:0]    out_r_q;
  logic             out_mode_q;
  logic [TAG_W-1:0] out_tag_q;

  logic [WIDTH-1:0] ll_cmp, ll_sel;

  // Global stall: every stage, bubbles included, holds while the output waits.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  half_mult #(.H(H)) u_ll (.a_i(in_a[H-1:0]),     .b_i(in_b[H-1:0]),     .p_o(ll_c));
  half_mult #(.H(H)) u_hl (.a_i(in_a[WIDTH-1:H]), .b_i(in_b[H-1:0]),     .p_o(hl_c));
  half_mult #(.H(H)) u_lh (.a_i(in_a[H-1:0]),     .b_i(in_b[WIDTH-1:H]), .p_o(lh_c));
  half_mult #(.H(H)) u_hh (.a_i(in_a[WIDTH-1:H]), .b_i(in_b[WIDTH-1:H]), .p_o(hh_c));

  // S2 combine: mode picks the exact or compensated low sub-product.
  always_comb begin
    ll_cmp   = WIDTH'(approx_ll(LL_MAX_W'(s1_ll_q), TRUNC));
    ll_sel   = (s1_mode_q == MODE_APPROX) ? ll_cmp : s1_ll_q;
    s2_sum_d = (RW'(s1_hh_q) << WIDTH)
             + ((RW'(s1_hl_q) + RW'(s1_lh_q)) << H)
             + RW'(ll_sel);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_ll_q     <= '0;
      s1_hl_q     <= '0;
      s1_lh_q     <= '0;
      s1_hh_q     <= '0;
      s1_mode_q   <= MODE_EXACT;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_sum_q    <= '0;
      s2_mode_q   <= MODE_EXACT;
      s2_tag_q    <= '0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_mode_q  <= MODE_EXACT;
      out_tag_q   <= '0;
    end else if (adv) begin
      s1_valid_q  <= in_valid;
      s1_ll_q     <= ll_c;
      s1_hl_q     <= hl_c;
      s1_lh_q     <= lh_c;
      s1_hh_q     <= hh_c;
      s1_mode_q   <= in_mode;
      s1_tag_q    <= in_tag;
      s2_valid_q  <= s1_valid_q;
      s2_sum_q    <= s2_sum_d;
      s2_mode_q   <= s1_mode_q;
      s2_tag_q    <= s1_tag_q;
      out_valid_q <= s2_valid_q;
      out_r_q     <= s2_sum_q;
      out_mode_q  <= s2_mode_q;
      out_tag_q   <= s2_tag_q;
    end
  end

  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_mode  = out_mode_q;
  assign out_tag   = out_tag_q;

endmodule
